// File: rtl/multibank_frame_buffer.sv
// multibank_frame_buffer
//   Rotating multi-bank frame store. The writer fills one bank of DEPTH words
//   while the reader drains previously committed banks in strict FIFO order.
//   A frame closes at the last address of a bank or early on write_last_i.
//   OVERFLOW_MODE 0 stalls the writer when its bank is occupied; mode 1 keeps
//   the writer ready and discards the excess words, counting them.
//
// Ports
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   write_data_i         signed input word
//   write_valid_i        write request
//   write_last_i         marks the final word of a frame
//   write_ready_o        writer may transfer
//   read_data_o          signed output word (registered)
//   read_valid_o         read_data_o is valid
//   read_ready_i         consumer accepts the current word
//   read_last_o          current output word ends its frame
//   frame_ready_o        one-cycle pulse after a bank commits
//   overflow_o           one-cycle pulse per discarded word
//   drop_count_o         saturating count of discarded words
//   full_banks_o         banks committed and not yet fully drained
//   debug_leds_o         {write_bank[1:0], read_bank[1:0], write_ready, read_valid}
module multibank_frame_buffer #(
  parameter int WIDTH         = 32,
  parameter int DEPTH         = 16,
  parameter int NUM_BANKS     = 2,
  parameter int OVERFLOW_MODE = 0,
  parameter int ADDR_WIDTH    = $clog2(DEPTH),
  parameter int BANK_WIDTH    = $clog2(NUM_BANKS)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [WIDTH-1:0]    write_data_i,
  input  logic                write_valid_i,
  input  logic                write_last_i,
  output logic                write_ready_o,
  output logic [WIDTH-1:0]    read_data_o,
  output logic                read_valid_o,
  input  logic                read_ready_i,
  output logic                read_last_o,
  output logic                frame_ready_o,
  output logic                overflow_o,
  output logic [15:0]         drop_count_o,
  output logic [BANK_WIDTH:0] full_banks_o,
  output logic [5:0]          debug_leds_o
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [BANK_WIDTH-1:0] LAST_BANK = BANK_WIDTH'(NUM_BANKS - 1);

  function automatic logic [BANK_WIDTH-1:0] next_bank(input logic [BANK_WIDTH-1:0] b);
    return (b == LAST_BANK) ? '0 : b + BANK_WIDTH'(1);
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic signed [WIDTH-1:0] mem [NUM_BANKS*DEPTH];
  // Index of the final word of each committed frame (stored length - 1).
  logic [ADDR_WIDTH-1:0]   bank_last [NUM_BANKS];
  // A bank is busy from commit until its last word is accepted (FULL/DRAINING).
  logic [NUM_BANKS-1:0]    bank_busy;

  logic [BANK_WIDTH-1:0]   wr_bank, rd_bank;
  logic [ADDR_WIDTH-1:0]   wr_addr, rd_addr;
  logic                    rd_done;
  logic signed [WIDTH-1:0] wdata_p0, data_p1;
  logic                    vld_p1, last_p1;
  logic                    commit_p1, drop_p1;
  logic [15:0]             drop_cnt;
  logic [BANK_WIDTH:0]     full_cnt;

  logic wr_free, wr_xfer, wr_accept, wr_drop, wr_commit;
  logic out_load, fetch_p0, fetch_last_p0, rd_release;
  logic [1:0] wb_led, rb_led;

  assign wdata_p0 = write_data_i;

  // ---- stage p0: write decode and read fetch decision ----
  always_comb begin
    wr_free       = ~bank_busy[wr_bank];
    write_ready_o = (OVERFLOW_MODE == 1) ? 1'b1 : wr_free;
    wr_xfer       = write_valid_i & write_ready_o;
    wr_accept     = wr_xfer & wr_free;
    wr_drop       = wr_xfer & ~wr_free;
    wr_commit     = wr_accept & (write_last_i | (wr_addr == LAST_ADDR));
    rd_release    = vld_p1 & read_ready_i & last_p1;
    // The output register may take a new word when empty or being consumed.
    out_load      = ~vld_p1 | read_ready_i;
    fetch_p0      = out_load & bank_busy[rd_bank] & ~rd_done;
    fetch_last_p0 = (rd_addr == bank_last[rd_bank]);
  end

  always_ff @(posedge clk_i) begin
    if (wr_accept) begin
      mem[{wr_bank, wr_addr}] <= wdata_p0;
    end
    if (wr_commit) begin
      bank_last[wr_bank] <= wr_addr;
    end
  end

  // ---- stage p1: bank bookkeeping and registered RAM output ----
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bank_busy <= '0;
      wr_bank   <= '0;
      wr_addr   <= '0;
      rd_bank   <= '0;
      rd_addr   <= '0;
      rd_done   <= 1'b0;
      data_p1   <= '0;
      vld_p1    <= 1'b0;
      last_p1   <= 1'b0;
      commit_p1 <= 1'b0;
      drop_p1   <= 1'b0;
      drop_cnt  <= '0;
      full_cnt  <= '0;
    end else begin
      commit_p1 <= wr_commit;
      drop_p1   <= wr_drop;
      if (wr_drop) begin
        drop_cnt <= sat_inc16(drop_cnt);
      end

      // Commit and release never target the same bank: the writer only
      // commits into a bank that is not busy, the reader only releases a busy one.
      for (int b = 0; b < NUM_BANKS; b++) begin
        if (wr_commit && (wr_bank == BANK_WIDTH'(b))) begin
          bank_busy[b] <= 1'b1;
        end else if (rd_release && (rd_bank == BANK_WIDTH'(b))) begin
          bank_busy[b] <= 1'b0;
        end
      end

      if (wr_accept) begin
        if (wr_commit) begin
          wr_addr <= '0;
          wr_bank <= next_bank(wr_bank);
        end else begin
          wr_addr <= wr_addr + ADDR_WIDTH'(1);
        end
      end

      case ({wr_commit, rd_release})
        2'b10:   full_cnt <= full_cnt + (BANK_WIDTH+1)'(1);
        2'b01:   full_cnt <= full_cnt - (BANK_WIDTH+1)'(1);
        default: full_cnt <= full_cnt;
      endcase

      if (out_load) begin
        vld_p1 <= fetch_p0;
      end
      if (fetch_p0) begin
        data_p1 <= mem[{rd_bank, rd_addr}];
        last_p1 <= fetch_last_p0;
        if (fetch_last_p0) begin
          // Whole frame fetched; wait for the consumer to take the last word.
          rd_done <= 1'b1;
        end else begin
          rd_addr <= rd_addr + ADDR_WIDTH'(1);
        end
      end

      if (rd_release) begin
        rd_done <= 1'b0;
        rd_addr <= '0;
        rd_bank <= next_bank(rd_bank);
      end
    end
  end

  generate
    if (BANK_WIDTH >= 2) begin : g_led_wide
      assign wb_led = wr_bank[1:0];
      assign rb_led = rd_bank[1:0];
    end else begin : g_led_narrow
      assign wb_led = {1'b0, wr_bank};
      assign rb_led = {1'b0, rd_bank};
    end
  endgenerate

  assign read_data_o   = data_p1;
  assign read_valid_o  = vld_p1;
  assign read_last_o   = last_p1;
  assign frame_ready_o = commit_p1;
  assign overflow_o    = drop_p1;
  assign drop_count_o  = drop_cnt;
  assign full_banks_o  = full_cnt;
  assign debug_leds_o  = {wb_led, rb_led, write_ready_o, vld_p1};

endmodule
